glitc_clock_controller: RTL and testbench

//  Control sequencer on clk_i that drives ctrl_i/phase_ctrl_i of the GLITC clock generator and consumes its status_o/phase_ctrl_o.

---
 rtl/glitc_clock_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_glitc_clock_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_clock_controller.sv
// GLITC clock controller: sequences MMCM reset, source and powerdown selection,
// supervises lock with auto-relock, and runs multi-step PSEN/PSDONE phase shifts.
module glitc_clock_controller #(
  parameter int RST_CYCLES     = 64,
  parameter int LOCK_TIMEOUT   = 2**20,
  parameter int PSDONE_TIMEOUT = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int PS_CNT_W       = 8,
  parameter int PS_POS_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                mult_sel_i,
  input  logic                mult_pwrdwn_i,
  input  logic                reset_req_i,
  input  logic                ps_req_i,
  input  logic                ps_dir_i,
  input  logic [PS_CNT_W-1:0] ps_count_i,
  input  logic                err_clr_i,
  output logic [2:0]          ctrl_o,
  input  logic [1:0]          status_i,
  output logic [7:0]          phase_ctrl_o,
  input  logic [7:0]          phase_ctrl_i,
  output logic                locked_o,
  output logic                busy_o,
  output logic [PS_POS_W-1:0] ps_pos_o,
  output logic [7:0]          lock_loss_cnt_o,
  output logic [2:0]          err_o
);

  localparam int MAX_WAIT_A = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int MAX_WAIT   = (MAX_WAIT_A > PSDONE_TIMEOUT) ? MAX_WAIT_A : PSDONE_TIMEOUT;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);
  localparam int RTY_W      = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_LOCKED     = 3'd2,
    ST_PS_STEP    = 3'd3,
    ST_PS_WAIT    = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          status_meta_r, status_sync_r;
  logic [1:0]          cfg_r, cfg_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [RTY_W-1:0]    retry_r, retry_s, retry_inc_s;
  logic [PS_CNT_W-1:0] rem_r, rem_s;
  logic                dir_r, dir_s;
  logic [PS_POS_W-1:0] pos_r, pos_s;
  logic [7:0]          loss_r;
  logic [2:0]          err_r, err_set_s;
  logic                rst_r, locked_r, busy_r, psen_r, psincdec_r;
  logic                sel_eff_s, cfg_change_s, lock_ok_s, lock_lost_s;
  logic                in_lock_state_s, ps_accept_s, psdone_s, loss_inc_s;
  logic                phase_ctrl_unused_s;

  assign sel_eff_s       = mult_sel_i & ~mult_pwrdwn_i;
  assign cfg_s           = {sel_eff_s, mult_pwrdwn_i};
  assign cfg_change_s    = (cfg_s != cfg_r);
  // Multiplier lock only matters when the multiplier actually feeds the MMCM
  assign lock_ok_s       = status_sync_r[0] & (~cfg_r[1] | status_sync_r[1]);
  assign in_lock_state_s = (state_r == ST_LOCKED) || (state_r == ST_PS_STEP) ||
                           (state_r == ST_PS_WAIT);
  assign lock_lost_s     = in_lock_state_s & ~lock_ok_s;
  assign ps_accept_s     = (state_r == ST_LOCKED) & ~cfg_change_s & ~lock_lost_s;
  assign psdone_s        = phase_ctrl_i[0];
  assign retry_inc_s     = retry_r + RTY_W'(1);
  assign phase_ctrl_unused_s = ^phase_ctrl_i[7:1];

  // Two-flop synchronizer for the generator's asynchronous lock flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_meta_r <= 2'b00;
      status_sync_r <= 2'b00;
    end else begin
      status_meta_r <= status_i;
      status_sync_r <= status_meta_r;
    end
  end

  // Next-state, sequencing counters and error/event strobes
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CNT_W'(1);
    retry_s    = retry_r;
    rem_s      = rem_r;
    dir_s      = dir_r;
    pos_s      = pos_r;
    loss_inc_s = 1'b0;
    err_set_s  = 3'b000;
    // A dropped request is an error unless an explicit reset request took the cycle
    err_set_s[2] = ps_req_i & ~reset_req_i & ~ps_accept_s;

    if (reset_req_i || cfg_change_s) begin
      state_s = ST_RESET_HOLD;
      cnt_s   = {CNT_W{1'b0}};
      retry_s = {RTY_W{1'b0}};
    end else if (lock_lost_s) begin
      state_s    = ST_RESET_HOLD;
      cnt_s      = {CNT_W{1'b0}};
      loss_inc_s = 1'b1;
    end else begin
      case (state_r)
        ST_RESET_HOLD: begin
          if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = ST_RESET_HOLD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok_s) begin
            state_s = ST_LOCKED;
            retry_s = {RTY_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
          end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
            err_set_s[0] = 1'b1;
            cnt_s        = {CNT_W{1'b0}};
            retry_s      = retry_inc_s;
            if (retry_inc_s >= RTY_W'(MAX_RETRIES)) begin
              state_s = ST_FAULT;
            end else begin
              state_s = ST_RESET_HOLD;
            end
          end else begin
            state_s = ST_WAIT_LOCK;
          end
        end
        ST_LOCKED: begin
          cnt_s = {CNT_W{1'b0}};
          if (ps_req_i && (ps_count_i != PS_CNT_W'(0))) begin
            state_s = ST_PS_STEP;
            rem_s   = ps_count_i;
            dir_s   = ps_dir_i;
          end else begin
            state_s = ST_LOCKED;
          end
        end
        ST_PS_STEP: begin
          state_s = ST_PS_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end
        ST_PS_WAIT: begin
          if (psdone_s) begin
            pos_s = dir_r ? (pos_r + PS_POS_W'(1)) : (pos_r - PS_POS_W'(1));
            rem_s = rem_r - PS_CNT_W'(1);
            cnt_s = {CNT_W{1'b0}};
            if (rem_r == PS_CNT_W'(1)) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_PS_STEP;
            end
          end else if (cnt_r == CNT_W'(PSDONE_TIMEOUT - 1)) begin
            err_set_s[1] = 1'b1;
            state_s      = ST_RESET_HOLD;
            cnt_s        = {CNT_W{1'b0}};
          end else begin
            state_s = ST_PS_WAIT;
          end
        end
        ST_FAULT: begin
          state_s = ST_FAULT;
          cnt_s   = {CNT_W{1'b0}};
        end
        default: begin
          state_s = ST_RESET_HOLD;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State register; outputs are registered from the next state so they align with it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_RESET_HOLD;
      cfg_r      <= 2'b00;
      cnt_r      <= {CNT_W{1'b0}};
      retry_r    <= {RTY_W{1'b0}};
      rem_r      <= {PS_CNT_W{1'b0}};
      dir_r      <= 1'b0;
      pos_r      <= {PS_POS_W{1'b0}};
      rst_r      <= 1'b1;
      locked_r   <= 1'b0;
      busy_r     <= 1'b1;
      psen_r     <= 1'b0;
      psincdec_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cfg_r      <= cfg_s;
      cnt_r      <= cnt_s;
      retry_r    <= retry_s;
      rem_r      <= rem_s;
      dir_r      <= dir_s;
      pos_r      <= (state_s == ST_RESET_HOLD) ? {PS_POS_W{1'b0}} : pos_s;
      rst_r      <= (state_s == ST_RESET_HOLD) || (state_s == ST_FAULT);
      locked_r   <= (state_s == ST_LOCKED) || (state_s == ST_PS_STEP) ||
                    (state_s == ST_PS_WAIT);
      busy_r     <= (state_s == ST_RESET_HOLD) || (state_s == ST_WAIT_LOCK) ||
                    (state_s == ST_PS_STEP) || (state_s == ST_PS_WAIT);
      psen_r     <= (state_s == ST_PS_STEP);
      psincdec_r <= ((state_s == ST_PS_STEP) || (state_s == ST_PS_WAIT)) & dir_s;
    end
  end

  // Sticky error flags and saturating lock-loss counter; a new event beats a clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r  <= 3'b000;
      loss_r <= 8'h00;
    end else begin
      err_r <= (err_r & ~{3{err_clr_i}}) | err_set_s;
      if (loss_inc_s && (loss_r != 8'hFF)) begin
        loss_r <= loss_r + 8'd1;
      end else begin
        loss_r <= loss_r;
      end
    end
  end

  assign ctrl_o          = {cfg_r, rst_r};
  assign phase_ctrl_o    = {6'b000000, psincdec_r, psen_r};
  assign locked_o        = locked_r;
  assign busy_o          = busy_r;
  assign ps_pos_o        = pos_r;
  assign lock_loss_cnt_o = loss_r;
  assign err_o           = err_r;

endmodule

// File: tb/tb_glitc_clock_controller.sv
// Directed bench for glitc_clock_controller with a PSDONE responder that
// also watches the PSEN protocol (single-cycle, one outstanding, never in reset).
module tb_glitc_clock_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mult_sel = 1'b0, mult_pwrdwn = 1'b0, reset_req = 1'b0;
  logic       ps_req = 1'b0, ps_dir = 1'b0, err_clr = 1'b0;
  logic [7:0] ps_count = 8'd0;
  logic [1:0] status = 2'b00;
  logic       psdone = 1'b0;
  logic [7:0] phase_in;
  logic [2:0] ctrl_o, err_o;
  logic [7:0] phase_ctrl_o, lock_loss_cnt_o;
  logic       locked_o, busy_o;
  logic [15:0] ps_pos_o;

  int checks = 0;
  int failures = 0;
  logic auto_done = 1'b1;
  int   done_wait = 0;
  int   psen_cnt = 0;
  int   viol = 0;
  logic psen_prev = 1'b0;

  assign phase_in = {7'b0000000, psdone};

  always #5 clk = ~clk;

  glitc_clock_controller #(.LOCK_TIMEOUT(100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mult_sel_i(mult_sel), .mult_pwrdwn_i(mult_pwrdwn),
    .reset_req_i(reset_req), .ps_req_i(ps_req), .ps_dir_i(ps_dir), .ps_count_i(ps_count),
    .err_clr_i(err_clr), .ctrl_o(ctrl_o), .status_i(status), .phase_ctrl_o(phase_ctrl_o),
    .phase_ctrl_i(phase_in), .locked_o(locked_o), .busy_o(busy_o), .ps_pos_o(ps_pos_o),
    .lock_loss_cnt_o(lock_loss_cnt_o), .err_o(err_o)
  );

  // PSDONE responder: answers each PSEN 12 cycles later and flags protocol breaches
  always @(posedge clk) begin
    #1;
    psdone = 1'b0;
    if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0) psdone = 1'b1;
    end
    if (phase_ctrl_o[0] === 1'b1) begin
      psen_cnt++;
      if (psen_prev || (done_wait > 0) || (ctrl_o[0] !== 1'b0)) viol++;
      if (auto_done) done_wait = 12;
    end
    psen_prev = phase_ctrl_o[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_locked(input int bound, output int n);
    n = 0;
    while (locked_o !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy_o !== 1'b0 && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic measure_hold(output int n);
    n = 0;
    while (ctrl_o[0] === 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int n;
    tick(3);
    check("rst_ctrl", 32'(ctrl_o), 32'h1);
    check("rst_phase", 32'(phase_ctrl_o), 32'h0);
    check("rst_locked", 32'(locked_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h1);
    check("rst_pos", 32'(ps_pos_o), 32'h0);
    check("rst_loss", 32'(lock_loss_cnt_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);

    // Initial reset pulse, then lock arrives 80 cycles after release
    rst_n = 1'b1;
    measure_hold(n);
    check("init_hold_len", 32'(n), 32'd64);
    tick(16);
    status = 2'b01;
    wait_locked(50, n);
    check("init_lock_latency", 32'(n), 32'd3);
    check("init_busy", 32'(busy_o), 32'h0);
    check("init_ctrl", 32'(ctrl_o), 32'h0);
    check("init_err", 32'(err_o), 32'h0);

    // Five increment steps
    ps_dir = 1'b1; ps_count = 8'd5; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    check("inc_first_psen", 32'(phase_ctrl_o), 32'h3);
    check("inc_busy", 32'(busy_o), 32'h1);
    tick(1);
    check("inc_dir_held", 32'(phase_ctrl_o), 32'h2);
    wait_idle(300, n);
    check("inc_pos", 32'(ps_pos_o), 32'd5);
    check("inc_psen_cnt", 32'(psen_cnt), 32'd5);
    check("inc_phase_idle", 32'(phase_ctrl_o), 32'h0);
    check("inc_locked", 32'(locked_o), 32'h1);

    // Two decrement steps
    ps_dir = 1'b0; ps_count = 8'd2; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    check("dec_first_psen", 32'(phase_ctrl_o), 32'h1);
    wait_idle(300, n);
    check("dec_pos", 32'(ps_pos_o), 32'd3);
    check("dec_psen_cnt", 32'(psen_cnt), 32'd7);

    // Zero-count request is a silent no-op
    ps_count = 8'd0; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    tick(2);
    check("zero_busy", 32'(busy_o), 32'h0);
    check("zero_err", 32'(err_o), 32'h0);
    check("zero_psen_cnt", 32'(psen_cnt), 32'd7);

    // Lock loss while locked
    status = 2'b00;
    n = 0;
    while (locked_o !== 1'b0 && n < 20) begin tick(1); n++; end
    check("loss_latency", 32'(n), 32'd3);
    check("loss_cnt", 32'(lock_loss_cnt_o), 32'd1);
    check("loss_pos_clr", 32'(ps_pos_o), 32'h0);
    check("loss_busy", 32'(busy_o), 32'h1);
    measure_hold(n);
    check("loss_hold_len", 32'(n), 32'd64);

    // Request during WAIT_LOCK is rejected without a PSEN
    ps_dir = 1'b1; ps_count = 8'd3; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    check("rej_err", 32'(err_o), 32'h4);
    tick(3);
    check("rej_psen_cnt", 32'(psen_cnt), 32'd7);
    pulse_err_clr();
    check("rej_err_clr", 32'(err_o), 32'h0);
    status = 2'b01;
    wait_locked(50, n);
    check("relock1", 32'(locked_o), 32'h1);

    // PSDONE withheld: step timeout then relock
    auto_done = 1'b0;
    ps_dir = 1'b1; ps_count = 8'd1; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    n = 0;
    while (err_o[1] !== 1'b1 && n < 200) begin tick(1); n++; end
    check("psto_latency", 32'(n), 32'd65);
    check("psto_err", 32'(err_o), 32'h2);
    check("psto_ctrl", 32'(ctrl_o), 32'h1);
    check("psto_locked", 32'(locked_o), 32'h0);
    check("psto_pos", 32'(ps_pos_o), 32'h0);
    check("psto_loss", 32'(lock_loss_cnt_o), 32'd1);
    check("psto_psen_cnt", 32'(psen_cnt), 32'd8);
    auto_done = 1'b1;
    wait_locked(100, n);
    check("relock2", 32'(locked_o), 32'h1);
    pulse_err_clr();
    check("psto_err_clr", 32'(err_o), 32'h0);

    // reset_req beats a simultaneous ps_req
    reset_req = 1'b1; ps_req = 1'b1;
    tick(1);
    reset_req = 1'b0; ps_req = 1'b0;
    check("rreq_ctrl", 32'(ctrl_o), 32'h1);
    check("rreq_err", 32'(err_o), 32'h0);
    check("rreq_busy", 32'(busy_o), 32'h1);
    // A new error event wins over a same-cycle clear
    ps_req = 1'b1; err_clr = 1'b1;
    tick(1);
    ps_req = 1'b0; err_clr = 1'b0;
    check("set_beats_clr", 32'(err_o), 32'h4);
    pulse_err_clr();
    wait_locked(100, n);
    check("relock3", 32'(locked_o), 32'h1);

    // Powered-down multiplier: select forced off, only sys lock needed
    mult_sel = 1'b1; mult_pwrdwn = 1'b1;
    tick(1);
    check("pwrdwn_ctrl_hold", 32'(ctrl_o), 32'h3);
    check("pwrdwn_locked", 32'(locked_o), 32'h0);
    wait_locked(100, n);
    check("pwrdwn_relock", 32'(locked_o), 32'h1);
    check("pwrdwn_ctrl_run", 32'(ctrl_o), 32'h2);

    // Multiplier selected but never locks: three timeouts into FAULT
    mult_pwrdwn = 1'b0;
    tick(1);
    check("sel_ctrl_hold", 32'(ctrl_o), 32'h5);
    n = 0;
    while (!(busy_o === 1'b0 && ctrl_o[0] === 1'b1) && n < 1000) begin tick(1); n++; end
    check("fault_latency", 32'(n), 32'd492);
    check("fault_err", 32'(err_o), 32'h1);
    check("fault_locked", 32'(locked_o), 32'h0);
    tick(20);
    check("fault_stays", 32'(ctrl_o), 32'h5);
    check("fault_busy", 32'(busy_o), 32'h0);
    status = 2'b11;
    reset_req = 1'b1;
    tick(1);
    reset_req = 1'b0;
    check("fault_exit_busy", 32'(busy_o), 32'h1);
    wait_locked(100, n);
    check("fault_relock", 32'(locked_o), 32'h1);
    check("fault_relock_ctrl", 32'(ctrl_o), 32'h4);
    check("fault_err_sticky", 32'(err_o), 32'h1);
    check("final_loss", 32'(lock_loss_cnt_o), 32'd1);
    check("psen_protocol", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
